// File: rtl/fb_write_arbiter_pkg.sv
// Shared definitions for the framebuffer write arbiter.
// Holds the FSM encoding, the framebuffer size defaults and the write-beat type.
package fb_write_arbiter_pkg;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 8;

    localparam int                FB_WORDS_RF_DEF   = 307200;
    localparam int                FB_WORDS_DISP_DEF = 110592;
    localparam logic [DATA_W-1:0] CLEAR_VAL_DEF     = 8'h00;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_PASS  = 1'b1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              wen;
    } fb_wr_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/fb_clear_counter.sv
// Clear address generator: walks 0..limit-1 and flags the last word.
// A restart returns it to 0 regardless of where it stands.
module fb_clear_counter
    import fb_write_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic              advance,
    input  logic [ADDR_W-1:0] limit,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              done
);

    assign done = (clr_addr == limit - ADDR_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (reset) begin
            clr_addr <= '0;
        end else if (restart) begin
            clr_addr <= '0;
        end else if (advance) begin
            clr_addr <= done ? '0 : clr_addr + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// Framebuffer write arbiter: clears the VGA BRAM, then forwards the write
// stream selected by mode through one register stage.
module fb_write_arbiter
    import fb_write_arbiter_pkg::*;
#(
    parameter int                FB_WORDS_RF   = FB_WORDS_RF_DEF,
    parameter int                FB_WORDS_DISP = FB_WORDS_DISP_DEF,
    parameter logic [DATA_W-1:0] CLEAR_VAL     = CLEAR_VAL_DEF
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              mode,
    input  logic              clear_req,
    input  logic [ADDR_W-1:0] rf_waddr,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              rf_wen,
    input  logic [ADDR_W-1:0] disp_waddr,
    input  logic [DATA_W-1:0] disp_data,
    input  logic              disp_wen,
    output logic [ADDR_W-1:0] vga_waddr,
    output logic [DATA_W-1:0] dina,
    output logic              ena,
    output logic              wea,
    output logic              clear_busy,
    output logic [7:0]        drop_count
);

    localparam logic [ADDR_W-1:0] LIMIT_RF   = ADDR_W'(FB_WORDS_RF);
    localparam logic [ADDR_W-1:0] LIMIT_DISP = ADDR_W'(FB_WORDS_DISP);

    logic [0:0]        state;
    logic              mode_q;
    logic              restart;
    logic [ADDR_W-1:0] limit;
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_done;
    fb_wr_t            sel_wr;
    fb_wr_t            nxt_wr;
    logic              nxt_busy;
    logic              drop;

    assign restart = clear_req | (mode ^ mode_q);
    assign limit   = mode ? LIMIT_DISP : LIMIT_RF;
    assign sel_wr  = mode ? {disp_waddr, disp_data, disp_wen}
                          : {rf_waddr, rf_data, rf_wen};

    fb_clear_counter u_clear_counter (
        .clk      (clk),
        .reset    (reset),
        .restart  (restart),
        .advance  (state == ST_CLEAR),
        .limit    (limit),
        .clr_addr (clr_addr),
        .done     (clr_done)
    );

    // The restart cycle itself issues nothing, so address 0 is never written twice.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch is inferred.
        nxt_wr   = '0;
        nxt_busy = 1'b0;
        drop     = 1'b0;
        if (restart) begin
            drop = sel_wr.wen;
        end else if (state == ST_CLEAR) begin
            nxt_wr   = '{addr: clr_addr, data: CLEAR_VAL, wen: 1'b1};
            nxt_busy = 1'b1;
            drop     = sel_wr.wen;
        end else begin
            nxt_wr = sel_wr;
            if (sel_wr.wen && (sel_wr.addr >= limit)) begin
                nxt_wr.wen = 1'b0;
                drop       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_CLEAR;
            vga_waddr  <= '0;
            dina       <= '0;
            ena        <= 1'b0;
            wea        <= 1'b0;
            clear_busy <= 1'b0;
            drop_count <= '0;
        end else begin
            if (restart) begin
                state <= ST_CLEAR;
            end else if ((state == ST_CLEAR) && clr_done) begin
                state <= ST_PASS;
            end
            vga_waddr  <= nxt_wr.addr;
            dina       <= nxt_wr.data;
            ena        <= nxt_wr.wen;
            wea        <= nxt_wr.wen;
            clear_busy <= nxt_busy;
            if (drop) begin
                drop_count <= sat_inc8(drop_count);
            end
        end
    end

    // Free-running copy so it tracks mode through reset and no change is seen on release.
    always_ff @(posedge clk) begin
        mode_q <= mode;
    end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Scoreboard bench for fb_write_arbiter with reduced framebuffer sizes.
module tb_fb_write_arbiter;

    localparam int RF_W   = 1200;
    localparam int DISP_W = 600;

    logic        clk = 1'b0;
    logic        reset;
    logic        mode;
    logic        clear_req;
    logic [18:0] rf_waddr, disp_waddr, vga_waddr;
    logic [7:0]  rf_data, disp_data, dina, drop_count;
    logic        rf_wen, disp_wen, ena, wea, clear_busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          cyc;
        logic [18:0] addr;
        logic [7:0]  data;
        logic        busy;
    } exp_t;

    exp_t exp_q[$];

    fb_write_arbiter #(
        .FB_WORDS_RF   (RF_W),
        .FB_WORDS_DISP (DISP_W),
        .CLEAR_VAL     (8'h00)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mode       (mode),
        .clear_req  (clear_req),
        .rf_waddr   (rf_waddr),
        .rf_data    (rf_data),
        .rf_wen     (rf_wen),
        .disp_waddr (disp_waddr),
        .disp_data  (disp_data),
        .disp_wen   (disp_wen),
        .vga_waddr  (vga_waddr),
        .dina       (dina),
        .ena        (ena),
        .wea        (wea),
        .clear_busy (clear_busy),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic expect_clear(input int first_cyc, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{cyc: first_cyc + i, addr: 19'(i), data: 8'h00, busy: 1'b1});
        end
    endtask

    task automatic expect_pass(input logic [18:0] a, input logic [7:0] d);
        exp_q.push_back('{cyc: cyc + 1, addr: a, data: d, busy: 1'b0});
    endtask

    // Monitor: every BRAM write must match the head of the queue in cycle and content.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL missing_write: addr %0d due at cycle %0d, not seen (now %0d)",
                         exp_q[0].addr, exp_q[0].cyc, cyc);
                void'(exp_q.pop_front());
            end
            if (ena === 1'b1) begin
                if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: addr %0d data %0h at cycle %0d, none expected",
                             vga_waddr, dina, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(vga_waddr), 32'(e.addr));
                    check("wr_data", 32'(dina), 32'(e.data));
                    check("wr_wea", 32'(wea), 32'd1);
                    check("wr_busy", 32'(clear_busy), 32'(e.busy));
                end
            end else begin
                check("idle_busy", 32'(clear_busy), 32'd0);
                check("idle_wea", 32'(wea), 32'd0);
            end
        end
    end

    initial begin
        reset      = 1'b1;
        mode       = 1'b0;
        clear_req  = 1'b0;
        rf_waddr   = '0;
        rf_data    = '0;
        rf_wen     = 1'b0;
        disp_waddr = '0;
        disp_data  = '0;
        disp_wen   = 1'b0;
        run(3);

        check("rst_waddr", 32'(vga_waddr), 32'd0);
        check("rst_dina", 32'(dina), 32'd0);
        check("rst_ena", 32'(ena), 32'd0);
        check("rst_wea", 32'(wea), 32'd0);
        check("rst_busy", 32'(clear_busy), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);

        // Reset release: full rangefinder clear, first write one cycle later.
        reset = 1'b0;
        expect_clear(cyc + 1, RF_W);
        run(RF_W + 1);
        check("rf_clear_end_busy", 32'(clear_busy), 32'd0);

        // Rangefinder pass-through; disparity writes ignored.
        rf_waddr = 19'd1000; rf_data = 8'hFF; rf_wen = 1'b1;
        disp_waddr = 19'd5; disp_data = 8'h11; disp_wen = 1'b1;
        expect_pass(19'd1000, 8'hFF);
        tick();
        check("pass_addr", 32'(vga_waddr), 32'd1000);
        check("pass_data", 32'(dina), 32'hFF);
        check("pass_ena", 32'(ena), 32'd1);
        rf_wen = 1'b0; disp_waddr = 19'd7;
        tick();
        check("disp_ignored_ena", 32'(ena), 32'd0);
        disp_wen = 1'b0;

        rf_wen = 1'b1;
        rf_waddr = 19'd0;    rf_data = 8'h01; expect_pass(19'd0, 8'h01);    tick();
        rf_waddr = 19'd1199; rf_data = 8'h7E; expect_pass(19'd1199, 8'h7E); tick();
        rf_waddr = 19'd523;  rf_data = 8'hC3; expect_pass(19'd523, 8'hC3);  tick();
        rf_waddr = 19'd1200; rf_data = 8'h99; tick();
        check("rf_limit_drop", 32'(drop_count), 32'd1);
        rf_wen = 1'b0;
        tick();

        // Mode change at clr_addr=500 restarts with the disparity limit.
        clear_req = 1'b1;
        expect_clear(cyc + 2, 500);
        tick();
        clear_req = 1'b0;
        run(500);
        mode = 1'b1;
        expect_clear(cyc + 2, DISP_W);
        tick();
        run(DISP_W);
        check("disp_last_addr", 32'(vga_waddr), 32'(DISP_W - 1));
        check("disp_last_busy", 32'(clear_busy), 32'd1);
        tick();
        check("disp_clear_end_busy", 32'(clear_busy), 32'd0);

        // Disparity pass-through with the limit boundary; rf ignored.
        disp_waddr = 19'd599; disp_data = 8'h3C; disp_wen = 1'b1;
        rf_waddr = 19'd3; rf_data = 8'h44; rf_wen = 1'b1;
        expect_pass(19'd599, 8'h3C);
        tick();
        disp_waddr = 19'd600; disp_data = 8'h55;
        tick();
        check("disp_limit_drop", 32'(drop_count), 32'd2);
        disp_wen = 1'b0; rf_wen = 1'b0;
        tick();

        // clear_req together with a mode change: single restart.
        clear_req = 1'b1; mode = 1'b0;
        expect_clear(cyc + 2, 400);
        tick();
        clear_req = 1'b0;
        rf_wen = 1'b1;
        for (int i = 0; i < 300; i++) begin
            rf_waddr = 19'(i);
            rf_data  = 8'(i);
            tick();
        end
        rf_wen = 1'b0;
        run(100);
        check("drop_saturated", 32'(drop_count), 32'hFF);

        // clear_req inside CLEAR restarts from 0.
        clear_req = 1'b1;
        expect_clear(cyc + 2, RF_W);
        tick();
        clear_req = 1'b0;
        run(RF_W + 1);
        check("restart_clear_end_busy", 32'(clear_busy), 32'd0);
        check("drop_held", 32'(drop_count), 32'hFF);

        // Reset mid-clear aborts at once; full clear follows release.
        clear_req = 1'b1;
        expect_clear(cyc + 2, 100);
        tick();
        clear_req = 1'b0;
        run(100);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort_ena", 32'(ena), 32'd0);
        check("abort_busy", 32'(clear_busy), 32'd0);
        check("abort_waddr", 32'(vga_waddr), 32'd0);
        check("abort_drop", 32'(drop_count), 32'd0);
        run(3);
        reset = 1'b0;
        expect_clear(cyc + 1, RF_W);
        run(RF_W + 1);
        check("reclear_end_busy", 32'(clear_busy), 32'd0);

        rf_waddr = 19'd7; rf_data = 8'h5A; rf_wen = 1'b1;
        expect_pass(19'd7, 8'h5A);
        tick();
        rf_wen = 1'b0;
        run(2);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
